// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared types and constants for the equation puzzle blocks.
// Revision : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int VAL_W_DEFAULT = 8;
    localparam int IDX_W         = 2;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TENS = 3'd1;
    localparam logic [2:0] ST_WAIT_ONES = 3'd2;
    localparam logic [2:0] ST_COMPARE   = 3'd3;
    localparam logic [2:0] ST_DONE_OK   = 3'd4;
    localparam logic [2:0] ST_DONE_FAIL = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_TENS = ST_WAIT_TENS,
        S_WAIT_ONES = ST_WAIT_ONES,
        S_COMPARE   = ST_COMPARE,
        S_DONE_OK   = ST_DONE_OK,
        S_DONE_FAIL = ST_DONE_FAIL
    } state_t;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/go_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : go_edge_detect
// Purpose  : Two-flop synchronizer plus rising-edge pulse for the Go button.
// Revision : 1.0 - initial release
// ============================================================================
module go_edge_detect (
    input  logic Clock,
    input  logic Resetn,
    input  logic Go,
    output logic go_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= Go;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign go_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/eq_answer_checker.sv
`default_nettype none
// ============================================================================
// Module   : eq_answer_checker
// Purpose  : Collects BCD answers digit by digit and checks them against the
//            latched expected values. Optional macro: CHECK_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eq_answer_checker
    import eq_pkg::*;
#(
    parameter int NUM_ANSWERS = 3,
    parameter int VAL_W       = VAL_W_DEFAULT
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         startCheck,
    input  logic [NUM_ANSWERS*VAL_W-1:0] expected,
    input  logic                         Go,
    input  logic [3:0]                   data_in,
    input  logic [6:0]                   OngoingTimer,
    output logic                         busy,
    output logic [IDX_W-1:0]             answer_idx,
    output logic [VAL_W-1:0]             entered_value,
    output logic                         invalid_digit,
    output logic                         done,
    output logic                         correct,
    output logic                         wrong,
    output logic                         timeout
`ifdef CHECK_RETRY_EN
    ,
    output logic [1:0]                   retries_left
`endif
);

    localparam logic [VAL_W-1:0] c_TEN      = VAL_W'(10);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_ANSWERS - 1);

    state_t                       r_state;
    logic [NUM_ANSWERS*VAL_W-1:0] r_expected;
    logic [3:0]                   r_tens;
`ifdef CHECK_RETRY_EN
    logic [1:0]                   r_retry_cnt;
`endif

    logic             w_go_pulse;
    logic             w_active;
    logic             w_timer_zero;
    logic             w_digit_ok;
    logic             w_match;
    logic [VAL_W-1:0] w_exp_sel;
    logic [VAL_W-1:0] w_tens_val;
    logic [VAL_W-1:0] w_full_val;

    go_edge_detect u_go_edge (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Go       (Go),
        .go_pulse (w_go_pulse)
    );

    assign w_active     = (r_state == S_WAIT_TENS) || (r_state == S_WAIT_ONES) ||
                          (r_state == S_COMPARE);
    assign w_timer_zero = (OngoingTimer == 7'd0);
    assign w_digit_ok   = is_bcd(data_in);
    assign w_exp_sel    = r_expected[int'(answer_idx)*VAL_W +: VAL_W];
    assign w_match      = (entered_value == w_exp_sel);
    assign w_tens_val   = VAL_W'(data_in) * c_TEN;
    assign w_full_val   = VAL_W'(r_tens) * c_TEN + VAL_W'(data_in);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state       <= S_IDLE;
            r_expected    <= '0;
            r_tens        <= '0;
            busy          <= 1'b0;
            answer_idx    <= '0;
            entered_value <= '0;
            invalid_digit <= 1'b0;
            done          <= 1'b0;
            correct       <= 1'b0;
            wrong         <= 1'b0;
            timeout       <= 1'b0;
`ifdef CHECK_RETRY_EN
            r_retry_cnt   <= '0;
            retries_left  <= '0;
`endif
        end else begin
            invalid_digit <= 1'b0;
            // Timer expiry wins over any digit press or compare result.
            if (w_active && w_timer_zero) begin
                r_state <= S_DONE_FAIL;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
                wrong   <= 1'b0;
                correct <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
                        if (startCheck) begin
                            r_state       <= S_WAIT_TENS;
                            r_expected    <= expected;
                            r_tens        <= '0;
                            answer_idx    <= '0;
                            entered_value <= '0;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            correct       <= 1'b0;
                            wrong         <= 1'b0;
                            timeout       <= 1'b0;
`ifdef CHECK_RETRY_EN
                            r_retry_cnt   <= '0;
                            retries_left  <= 2'd2;
`endif
                        end
                    end
                    S_WAIT_TENS: begin
                        if (w_go_pulse) begin
                            if (!w_digit_ok) begin
                                invalid_digit <= 1'b1;
                            end else begin
                                r_tens        <= data_in;
                                entered_value <= w_tens_val;
                                r_state       <= S_WAIT_ONES;
                            end
                        end
                    end
                    S_WAIT_ONES: begin
                        if (w_go_pulse) begin
                            if (!w_digit_ok) begin
                                invalid_digit <= 1'b1;
                            end else begin
                                entered_value <= w_full_val;
                                r_state       <= S_COMPARE;
                            end
                        end
                    end
                    S_COMPARE: begin
                        if (w_match) begin
                            if (answer_idx == c_LAST_IDX) begin
                                r_state <= S_DONE_OK;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                correct <= 1'b1;
                            end else begin
                                answer_idx    <= answer_idx + 1'b1;
                                entered_value <= '0;
                                r_state       <= S_WAIT_TENS;
                            end
`ifdef CHECK_RETRY_EN
                        end else if (r_retry_cnt != 2'd2) begin
                            // Retry the same answer; the budget spans the whole check.
                            r_retry_cnt   <= r_retry_cnt + 1'b1;
                            retries_left  <= retries_left - 1'b1;
                            entered_value <= '0;
                            r_state       <= S_WAIT_TENS;
`endif
                        end else begin
                            r_state <= S_DONE_FAIL;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            wrong   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_answer_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq_answer_checker
// Purpose  : Directed scoreboard bench for eq_answer_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eq_answer_checker;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        startCheck = 1'b0;
    logic [23:0] expected = '0;
    logic        Go = 1'b0;
    logic [3:0]  data_in = '0;
    logic [6:0]  OngoingTimer = 7'd60;
    logic        busy;
    logic [1:0]  answer_idx;
    logic [7:0]  entered_value;
    logic        invalid_digit;
    logic        done;
    logic        correct;
    logic        wrong;
    logic        timeout;
`ifdef CHECK_RETRY_EN
    logic [1:0]  retries_left;
`endif

    eq_answer_checker #(.NUM_ANSWERS(3), .VAL_W(8)) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .startCheck    (startCheck),
        .expected      (expected),
        .Go            (Go),
        .data_in       (data_in),
        .OngoingTimer  (OngoingTimer),
        .busy          (busy),
        .answer_idx    (answer_idx),
        .entered_value (entered_value),
        .invalid_digit (invalid_digit),
        .done          (done),
        .correct       (correct),
        .wrong         (wrong),
        .timeout       (timeout)
`ifdef CHECK_RETRY_EN
        ,
        .retries_left  (retries_left)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       inv;
        logic       c;
        logic       w;
        logic       t;
        logic [1:0] idx;
        logic [7:0] val;
    } rsp_t;

    rsp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input logic inv, input logic c, input logic w,
                                input logic t, input logic [1:0] idx, input logic [7:0] val);
        rsp_t r;
        r.inv = inv; r.c = c; r.w = w; r.t = t; r.idx = idx; r.val = val;
        return r;
    endfunction

    // Monitor: an invalid-digit pulse or a rising done is a DUT response.
    always @(negedge Clock) begin
        rsp_t got;
        rsp_t want;
        if (Resetn && (invalid_digit || (done && !prev_done))) begin
            got = mk(invalid_digit, correct, wrong, timeout, answer_idx, entered_value);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got %h want none", got);
            end else begin
                want = q.pop_front();
                chk("scoreboard", 32'(got), 32'(want));
            end
        end
        prev_done = done;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic press(input logic [3:0] d);
        data_in = d;
        Go = 1'b1;
        cyc(4);
        Go = 1'b0;
        cyc(3);
    endtask

    task automatic start();
        startCheck = 1'b1;
        cyc(1);
        startCheck = 1'b0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        cyc(2);
        Resetn = 1'b1;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_correct", correct, 0);
        chk("rst_wrong", wrong, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_idx", answer_idx, 0);
        chk("rst_value", entered_value, 0);
        chk("rst_invalid", invalid_digit, 0);
        Resetn = 1'b1;
        cyc(1);

        // All three answers correct, with exact verdict latency.
        expected = {8'd12, 8'd6, 8'd2};
        start();
        chk("s1_busy", busy, 1);
        chk("s1_idx0", answer_idx, 0);
        press(4'd0); press(4'd2);
        chk("s1_idx1", answer_idx, 1);
        press(4'd0); press(4'd6);
        chk("s1_idx2", answer_idx, 2);
        press(4'd1);
        data_in = 4'd2;
        Go = 1'b1;
        cyc(3);
        chk("s1_pre_done", done, 0);
        chk("s1_value12", entered_value, 12);
        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd12));
        cyc(1);
        chk("s1_done", done, 1);
        chk("s1_correct", correct, 1);
        Go = 1'b0;
        cyc(3);

        // Restart from DONE_OK, then a wrong second answer.
        start();
        chk("s2_done_clr", done, 0);
        chk("s2_correct_clr", correct, 0);
        chk("s2_busy", busy, 1);
        press(4'd0); press(4'd2); press(4'd0);
`ifdef CHECK_RETRY_EN
        press(4'd7);
        chk("s2_retry_busy", busy, 1);
        chk("s2_retry_idx", answer_idx, 1);
        chk("s2_retry_left", retries_left, 1);
        chk("s2_retry_value", entered_value, 0);
        chk("s2_retry_done", done, 0);
`else
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'd7));
        press(4'd7);
        chk("s2_done", done, 1);
        chk("s2_correct", correct, 0);
`endif

        // Invalid digit is flagged and leaves the entry untouched.
        do_reset();
        start();
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
        press(4'd12);
        chk("s3_value_kept", entered_value, 0);
        chk("s3_busy", busy, 1);
        press(4'd3);
        chk("s3_value30", entered_value, 30);

        // Timer hits zero in the same cycle as a ones-digit pulse.
        data_in = 4'd5;
        Go = 1'b1;
        cyc(2);
        OngoingTimer = 7'd0;
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd30));
        cyc(1);
        chk("s4_timeout", timeout, 1);
        chk("s4_wrong", wrong, 0);
        chk("s4_busy", busy, 0);
        Go = 1'b0;
        OngoingTimer = 7'd60;
        cyc(3);

        // Go held for 50 cycles, startCheck while busy.
        do_reset();
        expected = {8'd12, 8'd6, 8'd45};
        start();
        data_in = 4'd4;
        Go = 1'b1;
        cyc(10);
        chk("s5_value40", entered_value, 40);
        startCheck = 1'b1;
        cyc(1);
        startCheck = 1'b0;
        cyc(39);
        chk("s5_held_value", entered_value, 40);
        chk("s5_held_idx", answer_idx, 0);
        chk("s5_held_busy", busy, 1);
        Go = 1'b0;
        cyc(3);
        press(4'd5);
        chk("s5_idx1", answer_idx, 1);
        chk("s5_value_clr", entered_value, 0);

        // Asynchronous reset mid-entry.
        press(4'd1);
        chk("s6_value10", entered_value, 10);
        #2;
        Resetn = 1'b0;
        #1;
        chk("s6_async_busy", busy, 0);
        chk("s6_async_value", entered_value, 0);
        chk("s6_async_idx", answer_idx, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        cyc(1);
        start();
        chk("s6_restart_idx", answer_idx, 0);
        chk("s6_restart_busy", busy, 1);
        press(4'd7);
        chk("s6_value70", entered_value, 70);

        // Expected value above 99 can never match.
        do_reset();
        expected = {8'd12, 8'd6, 8'd200};
        start();
        press(4'd9);
`ifdef CHECK_RETRY_EN
        press(4'd9);
        chk("s7_retry_left", retries_left, 1);
        chk("s7_retry_busy", busy, 1);
`else
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd99));
        press(4'd9);
        chk("s7_done", done, 1);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eq_answer_checker.md
Name: eq_answer_checker

Overview:
- Answer-entry and checking end of the equation puzzle flow.
- The equation generator produces the expected solution values. This block latches them, collects the user's answers as BCD digits from the switches (one digit per Go press) and compares each answer against its expected value.
- It reports correct, wrong or timeout to the top-level game sequencer.
- It is timed by the shared countdown (OngoingTimer).

Parameters:
- NUM_ANSWERS, 3: number of unknowns to be answered, entered in order x, y, z.
- VAL_W, 8: width of each expected value and each entered value.

Ports:
- Clock  input  1  system clock
- Resetn  input  1  asynchronous active-low reset
- startCheck  input  1  one-cycle pulse; latches expected and starts entry
- expected  input  NUM_ANSWERS*VAL_W  packed expected answers; answer 0 in the LSBs
- Go  input  1  raw button level; a press is a 0->1 transition
- data_in  input  4  BCD digit from the switches
- OngoingTimer  input  7  remaining seconds from the shared timer
- busy  output  1  high while digits are being collected or compared
- answer_idx  output  2  index of the answer currently being entered
- entered_value  output  VAL_W  value assembled so far, for the HEX display
- invalid_digit  output  1  one-cycle pulse when a press carries data_in > 9
- done  output  1  high in any terminal state
- correct  output  1  high in DONE_OK
- wrong  output  1  high in DONE_FAIL on mismatch
- timeout  output  1  high in DONE_FAIL when the timer expired

Behaviour:
- Reset (Resetn low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; latched expected values, digit registers and index are 0.
- Go handling:
  - Go passes through a two-flop synchronizer followed by an edge register.
  - go_pulse is high for exactly one cycle per 0->1 transition of the synchronized signal. Holding Go produces no repeats.
- States: IDLE, WAIT_TENS, WAIT_ONES, COMPARE, DONE_OK, DONE_FAIL.
- IDLE:
  - On startCheck, latch expected, set answer_idx=0, clear entered_value, go to WAIT_TENS.
- WAIT_TENS:
  - On go_pulse with data_in<=9: tens=data_in, entered_value=tens*10, go to WAIT_ONES.
- WAIT_ONES:
  - On go_pulse with data_in<=9: entered_value=tens*10+data_in (zero-extended to VAL_W), go to COMPARE.
- Invalid digits (both WAIT states):
  - A go_pulse with data_in>9 pulses invalid_digit for one cycle and changes no state or value.
- COMPARE (exactly one cycle):
  - Compares entered_value with expected[answer_idx].
  - Match and answer_idx==NUM_ANSWERS-1: go to DONE_OK.
  - Match otherwise: answer_idx+1, clear entered_value, go to WAIT_TENS.
  - Mismatch: go to DONE_FAIL with wrong=1 (see the optional feature).
- Timeout:
  - In WAIT_TENS, WAIT_ONES or COMPARE, OngoingTimer==0 forces DONE_FAIL with timeout=1 and wrong=0.
  - Timeout has priority over go_pulse and over the COMPARE result in the same cycle.
- Terminal states:
  - DONE_OK and DONE_FAIL hold, with done=1, until the next startCheck. That startCheck clears the flags and restarts as from IDLE.
- busy=1 in WAIT_TENS, WAIT_ONES and COMPARE.
- startCheck while busy is ignored.
- Latency: Go press to digit accepted is 3 cycles (2 synchronizer + edge). The verdict is visible 1 cycle after the ones digit is accepted.
- Values above 99 are unreachable from entry; an expected value >99 can never match.
- A Resetn assertion mid-entry aborts immediately to IDLE.

Optional Feature:
- Macro: CHECK_RETRY_EN.
- Defined:
  - A mismatch in COMPARE increments a 2-bit retry counter, clears entered_value and returns to WAIT_TENS for the same answer_idx.
  - The third mismatch, counted across the whole check, goes to DONE_FAIL with wrong=1.
  - The counter is cleared on startCheck.
  - Adds output retries_left [1:0], which reads 2 at start.
- Not defined: the first mismatch goes to DONE_FAIL; no counter and no retries_left port.

Decomposition:
- Package eq_pkg:
  - State encoding localparams.
  - VAL_W default.
  - BCD_MAX=9.
  - Answer index width.
- Sub-module go_edge_detect: synchronizer plus rising-edge pulse. It is reused by the other equation blocks for Go.

Test Plan:
- Expected={z=12,y=6,x=2}. Presses 0,2 / 0,6 / 1,2 -> correct=1 and done=1 one cycle after the last ones digit is accepted; answer_idx steps 0,1,2.
- Same expected. Presses 0,2 then 0,7 -> wrong=1 after the second COMPARE, correct=0. With CHECK_RETRY_EN: WAIT_TENS for idx 1 and retries_left=1.
- data_in=12 on a press in WAIT_TENS -> invalid_digit high for 1 cycle, state and entered_value unchanged; next press with 3 -> entered_value=30.
- OngoingTimer reaches 0 while in WAIT_ONES, with a go_pulse in the same cycle -> DONE_FAIL, timeout=1, wrong=0.
- Go held high for 50 cycles -> exactly one digit accepted; startCheck pulsed while busy -> ignored.
- Resetn dropped asynchronously mid-entry (between clock edges) -> all outputs 0 immediately, IDLE; a new startCheck restarts at idx 0.
